mcs_bridge_hs: RTL and testbench
================================

MCS_BRIDGE_HS -- requirements
Module: mcs_bridge_hs

Interface
REQ-001 SHALL have parameter BRG_BASE, default 32'h4000_0000, bridge base address; hit when io_address[29:22] == BRG_BASE[31:24].
REQ-002 SHALL have parameter N_SLOT, default 4, number of slave chip selects (power of 2, >=2); SEL_W = log2(N_SLOT).
REQ-003 SHALL have parameter ADDR_W, default 20, slave word-address width; ADDR_W+SEL_W <= 22.
REQ-004 SHALL have parameter FIXED_LAT, default 0; 0 = completion on fp_ack; >0 = completion FIXED_LAT cycles after the REQ cycle, fp_ack ignored.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum REQ+WAIT cycles before forced completion (ack mode only).
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk  in  1  system clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 io_read_strobe  in  1  one-cycle read request.
REQ-010 io_write_strobe  in  1  one-cycle write request.
REQ-011 io_byte_enable  in  4  write byte lanes.
REQ-012 io_address  in  30  word address.
REQ-013 io_write_data  in  32  write data.
REQ-014 io_read_data  out  32  read data, valid while io_ready=1.
REQ-015 io_ready  out  1  one-cycle completion pulse.
REQ-016 fp_cs  out  N_SLOT  one-hot slave select.
REQ-017 fp_wr / fp_rd  out  1 each  one-cycle write/read pulse.
REQ-018 fp_addr  out  ADDR_W  slave word address; fp_wr_data out 32; fp_be out 4.
REQ-019 fp_rd_data  in  32  slave read data; fp_ack in 1 slave completion.
REQ-020 err_clr  in  1  clears sticky errors; err_timeout, err_overlap, err_miss  out  1 each  sticky flags.

Function
REQ-021 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-022 IDLE: on either strobe SHALL latch address, write data, byte enable, direction; hit -> REQ, miss -> DONE with err_miss set.
REQ-023 Both strobes in the same cycle SHALL be treated as a write and set err_overlap.
REQ-024 Slot = latched io_address[ADDR_W+SEL_W-1:ADDR_W]; fp_addr = latched io_address[ADDR_W-1:0].
REQ-025 REQ (exactly one cycle): fp_cs[slot]=1, fp_wr or fp_rd=1; then -> WAIT unless completing.
REQ-026 WAIT: fp_cs[slot], fp_addr, fp_wr_data, fp_be held; fp_wr=fp_rd=0.
REQ-027 Ack mode: fp_ack=1 in REQ or WAIT SHALL capture fp_rd_data (reads) and -> DONE.
REQ-028 Ack mode: cycle counter starts at 1 in REQ; reaching TIMEOUT without ack SHALL -> DONE, read data 32'hFFFF_FFFF, set err_timeout; ack and timeout in same cycle -> ack wins, no error.
REQ-029 Fixed mode: fp_rd_data captured and -> DONE on the FIXED_LAT-th WAIT cycle.
REQ-030 DONE (one cycle): io_ready=1, io_read_data = captured data (0 for writes and misses); fp_cs=0; -> IDLE.
REQ-031 Ack-mode minimum latency: strobe cycle n, REQ n+1, ack at n+1 -> io_ready at n+2.
REQ-032 Strobes outside IDLE SHALL be ignored and set err_overlap.
REQ-033 err_clr SHALL clear all error flags; a same-cycle set takes priority over clear.
REQ-034 io_read_data SHALL be 0 whenever io_ready=0.

Reset
REQ-035 reset SHALL force IDLE at the next edge, including mid-transaction; all outputs 0, counter 0, error flags 0; a pending transaction SHALL be dropped, with no io_ready.

Verification
REQ-036 Read, defaults: io_address=30'h1020_0005 read strobe, fp_ack+fp_rd_data=32'hCAFE_0001 in REQ -> fp_cs=4'b0100, fp_addr=20'h00005, fp_rd one cycle, io_ready+io_read_data=32'hCAFE_0001 two cycles after strobe.
REQ-037 Write with 3 wait states: io_address=30'h1010_0010, data 32'h1234_5678, be 4'b0011, ack 4 cycles after REQ -> fp_cs=4'b0010, fp_wr one cycle, data/be held until ack, io_ready one cycle after ack, read data 0.
REQ-038 Timeout: TIMEOUT=8, no ack -> io_ready 9 cycles after strobe, io_read_data=32'hFFFF_FFFF, err_timeout=1 until err_clr.
REQ-039 Miss: io_address=30'h0000_0100 -> no fp_cs, io_ready 1 cycle after strobe with data 0, err_miss=1; strobe while in WAIT -> ignored, err_overlap=1.
REQ-040 Reset in WAIT: assert reset -> next cycle fp_cs=0, io_ready never pulses; new read completes normally afterward.
REQ-041 FIXED_LAT=2: read with fp_ack held 0 -> io_ready 4 cycles after strobe with fp_rd_data sampled on the second WAIT cycle.

Source files
------------

// File: rtl/mcs_bridge_hs.sv
// mcs_bridge_hs: bridges single-cycle IO strobes from the processor IO bus
// onto a small set of chip-selected slaves. Slave completion comes either from
// fp_ack (with a timeout backstop) or from a fixed latency. Address misses,
// overlapping strobes and timeouts raise sticky error flags.
module mcs_bridge_hs #(
  parameter logic [31:0] BRG_BASE  = 32'h4000_0000,
  parameter int          N_SLOT    = 4,
  parameter int          ADDR_W    = 20,
  parameter int          FIXED_LAT = 0,
  parameter int          TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_read_strobe,
  input  logic              io_write_strobe,
  input  logic [3:0]        io_byte_enable,
  input  logic [29:0]       io_address,
  input  logic [31:0]       io_write_data,
  output logic [31:0]       io_read_data,
  output logic              io_ready,
  output logic [N_SLOT-1:0] fp_cs,
  output logic              fp_wr,
  output logic              fp_rd,
  output logic [ADDR_W-1:0] fp_addr,
  output logic [31:0]       fp_wr_data,
  output logic [3:0]        fp_be,
  input  logic [31:0]       fp_rd_data,
  input  logic              fp_ack,
  input  logic              err_clr,
  output logic              err_timeout,
  output logic              err_overlap,
  output logic              err_miss
);

  localparam int SEL_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_is_wr;
  logic [15:0]       r_cnt;
  logic [N_SLOT-1:0] r_cs;
  logic              r_wr;
  logic              r_rd;
  logic              r_ready;
  logic [31:0]       r_rdata;
  logic              r_err_tmo;
  logic              r_err_ovl;
  logic              r_err_miss;

  logic              w_strobe;
  logic              w_hit;
  logic [SEL_W-1:0]  w_slot;
  logic [N_SLOT-1:0] w_onehot;
  logic              w_unused;

  assign w_strobe = io_read_strobe | io_write_strobe;
  assign w_hit    = (io_address[29:22] == BRG_BASE[31:24]);
  assign w_slot   = io_address[ADDR_W+SEL_W-1:ADDR_W];
  assign w_onehot = {{(N_SLOT-1){1'b0}}, 1'b1} << w_slot;
  // address bits above the slot field are only used through the hit compare
  assign w_unused = &{1'b0, io_address};

  assign io_read_data = r_rdata;
  assign io_ready     = r_ready;
  assign fp_cs        = r_cs;
  assign fp_wr        = r_wr;
  assign fp_rd        = r_rd;
  assign fp_addr      = r_addr;
  assign fp_wr_data   = r_wdata;
  assign fp_be        = r_be;
  assign err_timeout  = r_err_tmo;
  assign err_overlap  = r_err_ovl;
  assign err_miss     = r_err_miss;

  // Transaction FSM with registered bus outputs and sticky error flags.
  // Error sets are written after the clear so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_is_wr    <= 1'b0;
      r_cnt      <= '0;
      r_cs       <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_err_tmo  <= 1'b0;
      r_err_ovl  <= 1'b0;
      r_err_miss <= 1'b0;
    end else begin
      if (err_clr) begin
        r_err_tmo  <= 1'b0;
        r_err_ovl  <= 1'b0;
        r_err_miss <= 1'b0;
      end
      // strobes arriving while busy are dropped but remembered as an overlap
      if (r_state != S_IDLE && w_strobe)
        r_err_ovl <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            r_addr  <= io_address[ADDR_W-1:0];
            r_wdata <= io_write_data;
            r_be    <= io_byte_enable;
            r_is_wr <= io_write_strobe;   // write wins if both strobes fire
            if (io_read_strobe && io_write_strobe)
              r_err_ovl <= 1'b1;
            if (w_hit) begin
              r_state <= S_REQ;
              r_cs    <= w_onehot;
              r_wr    <= io_write_strobe;
              r_rd    <= io_read_strobe & ~io_write_strobe;
              r_cnt   <= 16'd1;
            end else begin
              r_state    <= S_DONE;
              r_ready    <= 1'b1;
              r_rdata    <= '0;
              r_err_miss <= 1'b1;
            end
          end
        end

        S_REQ, S_WAIT: begin
          r_wr <= 1'b0;
          r_rd <= 1'b0;
          if (FIXED_LAT == 0) begin
            if (fp_ack) begin
              r_state <= S_DONE;
              r_cs    <= '0;
              r_ready <= 1'b1;
              r_rdata <= r_is_wr ? 32'h0 : fp_rd_data;
            end else if (r_cnt == 16'(TIMEOUT)) begin
              r_state   <= S_DONE;
              r_cs      <= '0;
              r_ready   <= 1'b1;
              r_rdata   <= r_is_wr ? 32'h0 : 32'hFFFF_FFFF;
              r_err_tmo <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= r_cnt + 16'd1;
            end
          end else begin
            // fixed mode: r_cnt is the index of the current WAIT cycle
            if (r_state == S_REQ) begin
              r_state <= S_WAIT;
            end else if (r_cnt == 16'(FIXED_LAT)) begin
              r_state <= S_DONE;
              r_cs    <= '0;
              r_ready <= 1'b1;
              r_rdata <= r_is_wr ? 32'h0 : fp_rd_data;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_rdata <= '0;
          r_cnt   <= '0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcs_bridge_hs.sv
// tb_mcs_bridge_hs: directed bench for mcs_bridge_hs. dut0 runs in ack mode
// with TIMEOUT=8, dut1 in fixed-latency mode (FIXED_LAT=2). Expected read data
// is queued when a strobe is driven and popped when io_ready is seen.
module tb_mcs_bridge_hs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rs0 = 1'b0, ws0 = 1'b0, rs1 = 1'b0, ws1 = 1'b0;
  logic [3:0]  be = '0;
  logic [29:0] addr = '0;
  logic [31:0] wd = '0, frd = '0;
  logic        ack = 1'b0, eclr = 1'b0;

  logic [31:0] rd0, rd1, fwd0, fwd1;
  logic        rdy0, rdy1, fwr0, fwr1, frdo0, frdo1;
  logic [3:0]  cs0, cs1, fbe0, fbe1;
  logic [19:0] fa0, fa1;
  logic        et0, eo0, em0, et1, eo1, em1;

  int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0;
  logic [31:0] q0[$], q1[$];

  always #5 clk = ~clk;

  mcs_bridge_hs #(.TIMEOUT(8)) dut0 (
    .clk(clk), .reset(reset), .io_read_strobe(rs0), .io_write_strobe(ws0),
    .io_byte_enable(be), .io_address(addr), .io_write_data(wd),
    .io_read_data(rd0), .io_ready(rdy0), .fp_cs(cs0), .fp_wr(fwr0), .fp_rd(frdo0),
    .fp_addr(fa0), .fp_wr_data(fwd0), .fp_be(fbe0), .fp_rd_data(frd), .fp_ack(ack),
    .err_clr(eclr), .err_timeout(et0), .err_overlap(eo0), .err_miss(em0));

  mcs_bridge_hs #(.FIXED_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .io_read_strobe(rs1), .io_write_strobe(ws1),
    .io_byte_enable(be), .io_address(addr), .io_write_data(wd),
    .io_read_data(rd1), .io_ready(rdy1), .fp_cs(cs1), .fp_wr(fwr1), .fp_rd(frdo1),
    .fp_addr(fa1), .fp_wr_data(fwd1), .fp_be(fbe1), .fp_rd_data(frd), .fp_ack(ack),
    .err_clr(eclr), .err_timeout(et1), .err_overlap(eo1), .err_miss(em1));

  task automatic step;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one strobe cycle, queue expected read data, return in the REQ cycle
  task automatic start(input int sel, input logic r, input logic w, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [31:0] exp);
    addr = a; wd = d; be = b; t0 = cyc;
    if (sel == 0) begin rs0 = r; ws0 = w; q0.push_back(exp); end
    else          begin rs1 = r; ws1 = w; q1.push_back(exp); end
    step;
    rs0 = 1'b0; ws0 = 1'b0; rs1 = 1'b0; ws1 = 1'b0;
  endtask

  // wait (bounded) for io_ready, check latency from strobe and popped data
  task automatic finish(input int sel, input string tag, input int exp_lat);
    logic [31:0] e;
    e = 32'hDEAD_BEEF;
    while (!(sel == 0 ? rdy0 : rdy1) && (cyc - t0) < 40) step;
    chk({tag, "_lat"}, 32'(cyc - t0), 32'(exp_lat));
    if (sel == 0) begin if (q0.size() > 0) e = q0.pop_front(); end
    else          begin if (q1.size() > 0) e = q1.pop_front(); end
    chk({tag, "_data"}, (sel == 0) ? rd0 : rd1, e);
    step;
    chk({tag, "_rdy_drop"}, {31'b0, (sel == 0) ? rdy0 : rdy1}, 32'h0);
    chk({tag, "_data_zero"}, (sel == 0) ? rd0 : rd1, 32'h0);
  endtask

  task automatic clear_err;
    eclr = 1'b1; step; eclr = 1'b0;
  endtask

  initial begin
    int seen;

    // reset state
    step; step;
    chk("rst_ready", {31'b0, rdy0}, 0);
    chk("rst_rdata", rd0, 0);
    chk("rst_cs", {28'b0, cs0}, 0);
    chk("rst_errs", {29'b0, et0, eo0, em0}, 0);
    reset = 1'b0;
    step;

    // basic read, ack in the REQ cycle
    start(0, 1, 0, 30'h1020_0005, 0, 0, 32'hCAFE_0001);
    chk("rd_cs", {28'b0, cs0}, 32'b0100);
    chk("rd_addr", {12'b0, fa0}, 32'h5);
    chk("rd_pulse", {30'b0, frdo0, fwr0}, 32'b10);
    frd = 32'hCAFE_0001; ack = 1'b1;
    step; ack = 1'b0;
    chk("rd_pulse_end", {31'b0, frdo0}, 0);
    chk("rd_cs_done", {28'b0, cs0}, 0);
    finish(0, "rd", 2);

    // write with wait states, stray strobe in WAIT
    start(0, 0, 1, 30'h1010_0010, 32'h1234_5678, 4'b0011, 32'h0);
    chk("wr_cs", {28'b0, cs0}, 32'b0010);
    chk("wr_pulse", {30'b0, frdo0, fwr0}, 32'b01);
    step;
    chk("wr_pulse_end", {31'b0, fwr0}, 0);
    chk("wr_data_hold", fwd0, 32'h1234_5678);
    chk("wr_be_hold", {28'b0, fbe0}, 32'b0011);
    step; rs0 = 1'b1;
    step; rs0 = 1'b0;
    chk("ovl_in_wait", {31'b0, eo0}, 1);
    chk("wr_cs_hold", {28'b0, cs0}, 32'b0010);
    step; ack = 1'b1;
    step; ack = 1'b0;
    finish(0, "wr", 6);
    clear_err;
    chk("ovl_clr", {31'b0, eo0}, 0);

    // read timeout
    start(0, 1, 0, 30'h1000_0000, 0, 0, 32'hFFFF_FFFF);
    chk("tmo_pre", {31'b0, et0}, 0);
    finish(0, "tmo", 9);
    step; step;
    chk("tmo_sticky", {31'b0, et0}, 1);
    clear_err;
    chk("tmo_clr", {31'b0, et0}, 0);

    // ack arrives in the same cycle the timeout would fire
    frd = 32'hA5A5_0F0F;
    start(0, 1, 0, 30'h1030_0001, 0, 0, 32'hA5A5_0F0F);
    chk("race_cs", {28'b0, cs0}, 32'b1000);
    while ((cyc - t0) < 8) step;
    ack = 1'b1;
    step; ack = 1'b0;
    finish(0, "race", 9);
    chk("race_no_tmo", {31'b0, et0}, 0);

    // miss, with err_clr in the same cycle (set wins)
    eclr = 1'b1;
    start(0, 1, 0, 30'h0000_0100, 0, 0, 32'h0);
    eclr = 1'b0;
    chk("miss_cs", {28'b0, cs0}, 0);
    chk("miss_flag", {31'b0, em0}, 1);
    finish(0, "miss", 1);
    clear_err;
    chk("miss_clr", {31'b0, em0}, 0);

    // both strobes: treated as write, overlap flagged
    start(0, 1, 1, 30'h1000_0004, 32'h0BAD_F00D, 4'hF, 32'h0);
    chk("both_pulse", {30'b0, frdo0, fwr0}, 32'b01);
    chk("both_ovl", {31'b0, eo0}, 1);
    ack = 1'b1;
    step; ack = 1'b0;
    finish(0, "both", 2);
    clear_err;

    // reset in WAIT drops the transaction
    start(0, 1, 0, 30'h1020_0007, 0, 0, 32'h0);
    step; step;
    reset = 1'b1;
    step; reset = 1'b0;
    chk("rst_wait_cs", {28'b0, cs0}, 0);
    chk("rst_wait_rdy", {31'b0, rdy0}, 0);
    chk("rst_wait_addr", {12'b0, fa0}, 0);
    q0.delete();
    seen = 0;
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin step; if (rdy0) seen++; end
    ack = 1'b0;
    chk("rst_no_ready", 32'(seen), 0);
    frd = 32'h1357_2468;
    start(0, 1, 0, 30'h1020_0005, 0, 0, 32'h1357_2468);
    ack = 1'b1;
    step; ack = 1'b0;
    finish(0, "post_rst", 2);

    // fixed latency: data sampled on the second WAIT cycle
    start(1, 1, 0, 30'h1020_0005, 0, 0, 32'h2222_0002);
    chk("fix_cs", {28'b0, cs1}, 32'b0100);
    chk("fix_pulse", {31'b0, frdo1}, 1);
    frd = 32'h1111_0001; step;
    frd = 32'h2222_0002; step;
    finish(1, "fix", 4);

    // fixed latency ignores fp_ack
    ack = 1'b1;
    start(1, 1, 0, 30'h1010_0003, 0, 0, 32'h3333_0003);
    frd = 32'h4444_0004; step;
    frd = 32'h3333_0003; step;
    finish(1, "fix_ack", 4);
    ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
